// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/branch compare and EX/MEM register; EX_MUL_EN adds an iterative shift-add multiplier.
// Latency 1 cycle (multiply N+2); stall holds upstream while a multiply runs; flush/reset squash EX/MEM to a bubble.
module ex_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   EX_in,
   input  logic [2:0]   MEM_in,
   input  logic [1:0]   WB_in,
   input  logic [4:0]   rs1,
   input  logic [4:0]   rs2,
   input  logic [4:0]   rd,
   input  logic [N-1:0] data1,
   input  logic [N-1:0] data2,
   input  logic [N-1:0] imm,
   input  logic [N-1:0] instruction,
   input  logic [N-1:0] pc,
   input  logic         flush,
   input  logic         wb_regwrite,
   input  logic [4:0]   wb_rd,
   input  logic [N-1:0] wb_data,
   output logic [2:0]   MEM_out,
   output logic [1:0]   WB_out,
   output logic [4:0]   rd_out,
   output logic [N-1:0] alu_result,
   output logic [N-1:0] store_data,
   output logic         branch_taken,
   output logic [N-1:0] branch_target,
   output logic         stall
);

   localparam int         SW   = $clog2(N);
   localparam logic [6:0] OP_R = 7'b0110011;

   logic [N-1:0]        fwd_a, fwd_b, op_b, alu_y, res;
   logic signed [N-1:0] a_s;
   logic [1:0]          aluop;
   logic                alusrc, alt, zero, mul_busy, mul_done;
   logic [2:0]          funct3;
   logic [6:0]          opcode;
   logic [SW-1:0]       shamt;
   logic                unused_bits;

   assign aluop  = EX_in[2:1];
   assign alusrc = EX_in[0];
   assign funct3 = instruction[14:12];
   assign opcode = instruction[6:0];
   assign alt    = instruction[30];

   // EX/MEM has priority over MEM/WB because it holds the younger write.
   always_comb begin
      fwd_a = data1;
      if (WB_out[0] && rd_out != 5'd0 && rd_out == rs1)
         fwd_a = alu_result;
      else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs1)
         fwd_a = wb_data;
      fwd_b = data2;
      if (WB_out[0] && rd_out != 5'd0 && rd_out == rs2)
         fwd_b = alu_result;
      else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs2)
         fwd_b = wb_data;
   end

   assign op_b  = alusrc ? imm : fwd_b;
   assign shamt = op_b[SW-1:0];
   assign a_s   = fwd_a;

   always_comb begin
      alu_y = fwd_a + op_b;
      case (aluop)
         2'b01: alu_y = fwd_a - op_b;
         2'b10: begin
            case (funct3)
               3'b000: if (alt && opcode == OP_R) alu_y = fwd_a - op_b;
               3'b001: alu_y = fwd_a << shamt;
               3'b010: alu_y = {{(N-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
               3'b011: alu_y = {{(N-1){1'b0}}, (fwd_a < op_b)};
               3'b100: alu_y = fwd_a ^ op_b;
               3'b101: begin
                  if (alt) alu_y = a_s >>> shamt;
                  else     alu_y = fwd_a >> shamt;
               end
               3'b110: alu_y = fwd_a | op_b;
               default: alu_y = fwd_a & op_b;
            endcase
         end
         default: alu_y = fwd_a + op_b;
      endcase
   end

`ifdef EX_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   state_t        state, state_nxt;
   logic          is_mul;
   logic [N-1:0]  mcand, mplier, prod;
   logic [SW-1:0] cnt;

   assign is_mul = aluop == 2'b10 && opcode == OP_R &&
                   instruction[31:25] == 7'b0000001 && funct3 == 3'b000;
   assign unused_bits = ^{instruction[24:15], instruction[11:7]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: if (is_mul) begin
            stall     = 1'b1;
            state_nxt = MUL;
         end
         MUL: begin
            stall = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush || !rst_n) begin
         stall     = 1'b0;
         state_nxt = IDLE;
      end
   end

   // Operands are captured once so later forwarding changes cannot disturb the product.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
      end else if (state == IDLE && is_mul) begin
         mcand  <= fwd_a;
         mplier <= fwd_b;
         prod   <= '0;
         cnt    <= '0;
      end else if (state == MUL) begin
         if (mplier[0]) prod <= prod + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   assign mul_busy = (state == IDLE && is_mul) || state == MUL;
   assign mul_done = state == DONE;
   assign res      = mul_done ? prod : alu_y;
`else
   assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};
   assign stall       = 1'b0;
   assign mul_busy    = 1'b0;
   assign mul_done    = 1'b0;
   assign res         = alu_y;
`endif

   assign zero = res == '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         MEM_out       <= '0;
         WB_out        <= '0;
         rd_out        <= '0;
         alu_result    <= '0;
         store_data    <= '0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
      end else if (flush || mul_busy) begin
         MEM_out      <= '0;
         WB_out       <= '0;
         rd_out       <= '0;
         branch_taken <= 1'b0;
      end else begin
         MEM_out       <= MEM_in;
         WB_out        <= WB_in;
         rd_out        <= rd;
         alu_result    <= res;
         store_data    <= fwd_b;
         branch_taken  <= MEM_in[0] & zero;
         branch_target <= pc + imm;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table through a scoreboard queue, plus multiply, flush and reset sequences.
module tb_ex_stage;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   EX_in, MEM_in;
   logic [1:0]   WB_in;
   logic [4:0]   rs1, rs2, rd, wb_rd;
   logic [N-1:0] data1, data2, imm, instruction, pc, wb_data;
   logic         flush, wb_regwrite;
   logic [2:0]   MEM_out;
   logic [1:0]   WB_out;
   logic [4:0]   rd_out;
   logic [N-1:0] alu_result, store_data, branch_target;
   logic         branch_taken, stall;

   always #5 clk = ~clk;

   ex_stage #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .EX_in(EX_in), .MEM_in(MEM_in), .WB_in(WB_in),
      .rs1(rs1), .rs2(rs2), .rd(rd), .data1(data1), .data2(data2), .imm(imm),
      .instruction(instruction), .pc(pc), .flush(flush), .wb_regwrite(wb_regwrite),
      .wb_rd(wb_rd), .wb_data(wb_data), .MEM_out(MEM_out), .WB_out(WB_out),
      .rd_out(rd_out), .alu_result(alu_result), .store_data(store_data),
      .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall)
   );

   typedef struct packed {
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] sd;
      logic        bt;
      logic [31:0] tgt;
   } out_t;

   typedef struct {
      string       name;
      logic [2:0]  ex, mem;
      logic [1:0]  wb;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, ins, pc;
      logic        wrw;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        fl;
      out_t        exp;
   } vec_t;

   vec_t tbl[$];
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(
      input string nm, input logic [2:0] ex, input logic [2:0] mem, input logic [1:0] wb,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
      input logic [31:0] ins, input logic [31:0] pcv,
      input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat, input logic fl,
      input logic [2:0] emem, input logic [1:0] ewb, input logic [4:0] erd,
      input logic [31:0] ealu, input logic [31:0] esd, input logic ebt, input logic [31:0] etgt);
      vec_t v;
      v.name = nm; v.ex = ex; v.mem = mem; v.wb = wb;
      v.rs1 = r1; v.rs2 = r2; v.rd = rdv;
      v.d1 = d1; v.d2 = d2; v.imm = im; v.ins = ins; v.pc = pcv;
      v.wrw = wrw; v.wrd = wrd; v.wdat = wdat; v.fl = fl;
      v.exp = '{mem: emem, wb: ewb, rd: erd, alu: ealu, sd: esd, bt: ebt, tgt: etgt};
      return v;
   endfunction

   task automatic drive(input vec_t v);
      EX_in = v.ex; MEM_in = v.mem; WB_in = v.wb;
      rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
      data1 = v.d1; data2 = v.d2; imm = v.imm; instruction = v.ins; pc = v.pc;
      wb_regwrite = v.wrw; wb_rd = v.wrd; wb_data = v.wdat; flush = v.fl;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm);
      out_t a, e;
      a = '{mem: MEM_out, wb: WB_out, rd: rd_out, alu: alu_result, sd: store_data,
            bt: branch_taken, tgt: branch_target};
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got output %0h expected no pending entry", nm, a);
      end else begin
         e = sb.pop_front();
         chk(nm, 128'(a), 128'(e));
      end
   endtask

   // Runs one vector: drive, check stall, one edge, compare against the scoreboard.
   task automatic apply(input vec_t v);
      drive(v);
      sb.push_back(v.exp);
      #1;
      chk({v.name, "_stall"}, 128'(stall), 128'(0));
      @(posedge clk);
      #1;
      cmp(v.name);
   endtask

   task automatic run_mul(input vec_t v);
      int n = 0;
      drive(v);
      sb.push_back(v.exp);
      #1;
      while (stall && n < 40) begin
         n++;
         @(posedge clk);
         #1;
         wb_data = 32'h7;
         chk({v.name, "_bubble"}, 128'({MEM_out, WB_out, rd_out, branch_taken}), 128'(0));
      end
      chk({v.name, "_stall_cycles"}, 128'(n), 128'(33));
      @(posedge clk);
      #1;
      cmp(v.name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //      name                  ex      mem     wb     rs1   rs2   rd     d1            d2            imm           ins           pc            wrw  wrd   wdat          fl    emem    ewb    erd    ealu          esd           ebt   etgt
      tbl.push_back(mk("fwd_setup",        3'b000, 3'b000, 2'b01, 5'd1, 5'd2, 5'd5,  32'h10,       32'h0,        32'h0,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd5,  32'h10,       32'h0,        1'b0, 32'h0));
      tbl.push_back(mk("fwd_exmem_a",      3'b000, 3'b000, 2'b01, 5'd5, 5'd2, 5'd6,  32'h99,       32'h3,        32'h0,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd6,  32'h13,       32'h3,        1'b0, 32'h0));
      tbl.push_back(mk("dh_setup",         3'b000, 3'b000, 2'b01, 5'd1, 5'd2, 5'd7,  32'hA,        32'h0,        32'h0,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd7,  32'hA,        32'h0,        1'b0, 32'h0));
      tbl.push_back(mk("dh_exmem_wins",    3'b000, 3'b000, 2'b01, 5'd1, 5'd7, 5'd8,  32'h100,      32'h55,       32'h0,        32'h33,       32'h0,        1'b1, 5'd7, 32'hB,        1'b0, 3'b000, 2'b01, 5'd8,  32'h10A,      32'hA,        1'b0, 32'h0));
      tbl.push_back(mk("fwd_memwb_a",      3'b000, 3'b000, 2'b01, 5'd9, 5'd2, 5'd0,  32'h1,        32'h6,        32'h0,        32'h33,       32'h0,        1'b1, 5'd9, 32'h1234,     1'b0, 3'b000, 2'b01, 5'd0,  32'h123A,     32'h6,        1'b0, 32'h0));
      tbl.push_back(mk("rd0_no_fwd",       3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd1,  32'h20,       32'h3,        32'h0,        32'h33,       32'h0,        1'b1, 5'd0, 32'hDEAD,     1'b0, 3'b000, 2'b00, 5'd1,  32'h23,       32'h3,        1'b0, 32'h0));
      tbl.push_back(mk("no_fwd_no_regwr",  3'b000, 3'b000, 2'b10, 5'd1, 5'd2, 5'd2,  32'h40,       32'h2,        32'h0,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b10, 5'd2,  32'h42,       32'h2,        1'b0, 32'h0));
      tbl.push_back(mk("beq_taken",        3'b010, 3'b001, 2'b00, 5'd3, 5'd4, 5'd0,  32'h55,       32'h55,       32'h20,       32'h63,       32'h100,      1'b0, 5'd0, 32'h0,        1'b0, 3'b001, 2'b00, 5'd0,  32'h0,        32'h55,       1'b1, 32'h120));
      tbl.push_back(mk("beq_not_taken",    3'b010, 3'b001, 2'b00, 5'd3, 5'd4, 5'd0,  32'h55,       32'h56,       32'h20,       32'h63,       32'h100,      1'b0, 5'd0, 32'h0,        1'b0, 3'b001, 2'b00, 5'd0,  32'hFFFFFFFF, 32'h56,       1'b0, 32'h120));
      tbl.push_back(mk("addi_bit30",       3'b101, 3'b000, 2'b01, 5'd3, 5'd4, 5'd3,  32'h100,      32'h7777,     32'hFFFFFFFF, 32'h40000013, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd3,  32'hFF,       32'h7777,     1'b0, 32'hFFFFFFFF));
      tbl.push_back(mk("aluop11_add",      3'b110, 3'b000, 2'b01, 5'd10, 5'd11, 5'd4, 32'h5,        32'h7,        32'h20,       32'h33,       32'hFFFFFFF0, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd4,  32'hC,        32'h7,        1'b0, 32'h10));
      tbl.push_back(mk("sub",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'h3,        32'h5,        32'h0,        32'h40000033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'hFFFFFFFE, 32'h5,        1'b0, 32'h0));
      tbl.push_back(mk("sra",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'h80000000, 32'h4,        32'h0,        32'h40005033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'hF8000000, 32'h4,        1'b0, 32'h0));
      tbl.push_back(mk("srl",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'h80000000, 32'h4,        32'h0,        32'h00005033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'h08000000, 32'h4,        1'b0, 32'h0));
      tbl.push_back(mk("sll_shamt_mask",   3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'h1,        32'h23,       32'h0,        32'h00001033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'h8,        32'h23,       1'b0, 32'h0));
      tbl.push_back(mk("slt",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h00002033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'h1,        32'h1,        1'b0, 32'h0));
      tbl.push_back(mk("sltu",             3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h00003033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'h0,        32'h1,        1'b0, 32'h0));
      tbl.push_back(mk("xor",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'hF0F0,     32'hFF00,     32'h0,        32'h00004033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'h0FF0,     32'hFF00,     1'b0, 32'h0));
      tbl.push_back(mk("or",               3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'hF0F0,     32'hFF00,     32'h0,        32'h00006033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'hFFF0,     32'hFF00,     1'b0, 32'h0));
      tbl.push_back(mk("and",              3'b100, 3'b000, 2'b00, 5'd10, 5'd11, 5'd0, 32'hF0F0,     32'hFF00,     32'h0,        32'h00007033, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b00, 5'd0,  32'hF000,     32'hFF00,     1'b0, 32'h0));
      tbl.push_back(mk("flush_bubble",     3'b000, 3'b010, 2'b01, 5'd10, 5'd11, 5'd9, 32'h1,        32'h2,        32'h0,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 3'b000, 2'b00, 5'd0,  32'hF000,     32'hFF00,     1'b0, 32'h0));
      tbl.push_back(mk("store_alusrc",     3'b001, 3'b110, 2'b00, 5'd12, 5'd13, 5'd0, 32'h1000,     32'hCAFE,     32'h8,        32'h33,       32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 3'b110, 2'b00, 5'd0,  32'h1008,     32'hCAFE,     1'b0, 32'h8));
      tbl.push_back(mk("wb_passthru",      3'b000, 3'b100, 2'b11, 5'd12, 5'd13, 5'd31, 32'h1,       32'h1,        32'h4,        32'h33,       32'h40,       1'b0, 5'd0, 32'h0,        1'b0, 3'b100, 2'b11, 5'd31, 32'h2,        32'h1,        1'b0, 32'h44));
`ifndef EX_MUL_EN
      tbl.push_back(mk("mul_enc_as_add",   3'b100, 3'b000, 2'b01, 5'd14, 5'd15, 5'd10, 32'h3,       32'h5,        32'h0,        32'h02000033, 32'h200,      1'b0, 5'd0, 32'h0,        1'b0, 3'b000, 2'b01, 5'd10, 32'h8,        32'h5,        1'b0, 32'h200));
`endif

      // Reset state with an idle bus.
      rst_n = 1'b0;
      drive(mk("idle", 3'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               1'b0, 5'd0, 32'h0, 1'b0, 3'b0, 2'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0));
      sb.push_back('0);
      #1;
      chk("reset_stall", 128'(stall), 128'(0));
      @(posedge clk);
      #1;
      cmp("reset_state");
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

`ifdef EX_MUL_EN
      run_mul(mk("mul_basic",       3'b100, 3'b000, 2'b01, 5'd14, 5'd15, 5'd10, 32'h00010003, 32'h5, 32'h0, 32'h02000033, 32'h200,
                 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b01, 5'd10, 32'h0005000F, 32'h5, 1'b0, 32'h200));
      // rs1 comes from MEM/WB at start; wb_data is changed afterwards and must be ignored.
      run_mul(mk("mul_wrap_fwd",    3'b100, 3'b000, 2'b01, 5'd20, 5'd21, 5'd11, 32'h12345678, 32'h2, 32'h0, 32'h02000033, 32'h300,
                 1'b1, 5'd20, 32'hFFFFFFFF, 1'b0, 3'b000, 2'b01, 5'd11, 32'hFFFFFFFE, 32'h2, 1'b0, 32'h300));

      v = mk("mul_flushed", 3'b100, 3'b000, 2'b01, 5'd14, 5'd15, 5'd12, 32'h00010003, 32'h5, 32'h0, 32'h02000033, 32'h400,
             1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 5'd0, 32'hFFFFFFFE, 32'h2, 1'b0, 32'h300);
      drive(v);
      #1;
      chk("mul_start_stall", 128'(stall), 128'(1));
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      chk("mul_cycle10_stall", 128'(stall), 128'(1));
      flush = 1'b1;
      #1;
      chk("flush_stall_drop", 128'(stall), 128'(0));
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      cmp("flush_mid_mul");
      apply(mk("add_after_flush", 3'b000, 3'b000, 2'b01, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h33, 32'h0,
               1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b01, 5'd3, 32'h3, 32'h2, 1'b0, 32'h0));
`endif

      // Reset while busy (mid-multiply when the multiplier is built in).
      drive(mk("mul_reset", 3'b100, 3'b000, 2'b01, 5'd14, 5'd15, 5'd12, 32'h00010003, 32'h5, 32'h0, 32'h02000033, 32'h500,
               1'b0, 5'd0, 32'h0, 1'b0, 3'b0, 2'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0));
      #1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("reset_stall_drop", 128'(stall), 128'(0));
      sb.push_back('0);
      @(posedge clk);
      #1;
      cmp("reset_mid_mul");
      rst_n = 1'b1;
      apply(mk("add_after_reset", 3'b000, 3'b000, 2'b01, 5'd1, 5'd2, 5'd4, 32'h5, 32'h6, 32'h0, 32'h33, 32'h0,
               1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b01, 5'd4, 32'hB, 32'h6, 1'b0, 32'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
